// File: rtl/mips_pkg.sv
// Shared MIPS encodings, word type and sequencer state for the next-PC stage.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Branch immediates count words: sign-extend and scale to bytes.
  function automatic word_t branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational control-flow target for the executing instruction (no stall/halt/trap priority).
module pc_target_calc
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] instr,
  input  logic [WORD_W-1:0] rs_val,
  input  logic [WORD_W-1:0] rt_val,
  output logic [WORD_W-1:0] target,
  output logic              is_link,
  output logic              is_reg_jump
);

  logic [WORD_W-1:0] pc4;
  logic [5:0]        opcode;
  logic [5:0]        funct;

  assign pc4    = pc_in + 32'd4;
  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    target      = pc4;
    is_link     = 1'b0;
    is_reg_jump = 1'b0;
    case (opcode)
      OP_BEQ: if (rs_val == rt_val) target = pc4 + branch_offset(instr[15:0]);
      OP_BNE: if (rs_val != rt_val) target = pc4 + branch_offset(instr[15:0]);
      OP_J:   target = {pc4[31:28], instr[25:0], 2'b00};
      OP_JAL: begin
        target  = {pc4[31:28], instr[25:0], 2'b00};
        is_link = 1'b1;
      end
      OP_RTYPE: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          target      = rs_val;
          is_reg_jump = 1'b1;
          is_link     = (funct == FN_JALR);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC stage for the two-phase fetch/execute memory; updates only on execute edges.
// Build option: MISALIGN_TRAP_EN routes misaligned JR/JALR targets to TRAP_VECTOR.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WORD_W-1:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter logic [WORD_W-1:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              E,
  input  logic [WORD_W-1:0] PC_in,
  input  logic [WORD_W-1:0] instr,
  input  logic [WORD_W-1:0] rs_val,
  input  logic [WORD_W-1:0] rt_val,
  input  logic              stall,
  input  logic              halt_req,
  output logic [WORD_W-1:0] Next_PC,
  output logic [WORD_W-1:0] link_addr,
  output logic              link_we,
  output logic              halted,
  output logic              trap
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] next_pc_q, next_pc_d;
  logic              halted_q, halted_d;
  logic              trap_q, trap_d;

  logic [WORD_W-1:0] calc_target;
  logic              calc_is_link;
  logic              calc_is_reg_jump;
  logic [WORD_W-1:0] flow_target;
  logic              exec;
  logic              halt_hit;
  logic              misalign;

  pc_target_calc u_target_calc (
    .pc_in       (PC_in),
    .instr       (instr),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .target      (calc_target),
    .is_link     (calc_is_link),
    .is_reg_jump (calc_is_reg_jump)
  );

  assign exec     = E && (state_q == ST_RUN);
  assign halt_hit = halt_req || (instr == HALT_WORD);

`ifdef MISALIGN_TRAP_EN
  assign misalign    = calc_is_reg_jump && (rs_val[1:0] != 2'b00);
  assign flow_target = calc_target;
`else
  // Without the trap, register jumps silently drop the byte-offset bits.
  assign misalign    = 1'b0;
  assign flow_target = calc_is_reg_jump ? {calc_target[WORD_W-1:2], 2'b00} : calc_target;
`endif

  always_comb begin
    state_d   = state_q;
    next_pc_d = next_pc_q;
    halted_d  = halted_q;
    trap_d    = trap_q;
    if (exec) begin
      if (halt_hit) begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end else if (misalign) begin
        next_pc_d = TRAP_VECTOR;
        trap_d    = 1'b1;
      end else if (stall) begin
        next_pc_d = PC_in;
      end else begin
        next_pc_d = flow_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so every flop samples the pre-edge values.
    if (Reset) begin
      state_q   <= ST_RUN;
      next_pc_q <= RESET_VECTOR;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      next_pc_q <= next_pc_d;
      halted_q  <= halted_d;
      trap_q    <= trap_d;
    end
  end

  assign Next_PC   = next_pc_q;
  assign halted    = halted_q;
  assign trap      = trap_q;
  assign link_addr = PC_in + 32'd4;
  assign link_we   = exec && !halt_hit && !stall && !misalign && calc_is_link;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Upstream next-PC stage for the two-phase (fetch/execute) main memory. Consumes the memory's phase flag, the executing instruction and its address. Produces the registered Next_PC driving memory fetch, plus link data for JAL/JALR. Implements sequential flow, BEQ/BNE, J/JAL, JR/JALR, stall-replay and halt.

Parameters:
RESET_VECTOR, 32'h0000_0000, Next_PC value after reset.
TRAP_VECTOR, 32'h0000_0080, target on misaligned register jump (optional feature only).
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts the sequencer.

Ports:
clk  in  1  single clock; all state updates on posedge
Reset  in  1  synchronous, active-high reset
E  in  1  memory phase: 0 = fetch cycle, 1 = execute cycle
PC_in  in  32  address of executing instruction (memory PC_out)
instr  in  32  executing instruction (memory Mout during E=1)
rs_val  in  32  register rs value from datapath
rt_val  in  32  register rt value from datapath
stall  in  1  replay current instruction
halt_req  in  1  external halt request
Next_PC  out  32  registered next fetch address to memory
link_addr  out  32  PC_in+4, combinational
link_we  out  1  write link_addr to $ra/rd this execute cycle
halted  out  1  sequencer in HALT
trap  out  1  sticky misaligned-target flag (0 when feature off)

Behaviour:
- Reset (sync, sampled at posedge): Next_PC<=RESET_VECTOR, state<=RUN, halted<=0, trap<=0. Overrides everything, including mid-execute and HALT.
- States: RUN, HALT. RUN->HALT at an E=1 edge when halt_req=1 or instr==HALT_WORD. HALT exits only via Reset.
- Next_PC changes only at posedges where E=1 and state=RUN. Held constant through every E=0 edge, so the fetch edge and the following execute edge see the same value.
- Target selection at an E=1 edge, priority high to low:
  - halt: Next_PC held.
  - stall: Next_PC<=PC_in (refetch same instruction; no link).
  - opcode 6'h04 BEQ, taken iff rs_val==rt_val: PC_in+4+(sext(instr[15:0])<<2).
  - opcode 6'h05 BNE, taken iff rs_val!=rt_val: same target as BEQ.
  - opcode 6'h02 J / 6'h03 JAL: {pc4[31:28], instr[25:0], 2'b00}.
  - opcode 6'h00 with funct 6'h08 JR / 6'h09 JALR: rs_val.
  - otherwise, including a not-taken branch: PC_in+4.
- Arithmetic is 32-bit modulo 2^32: PC_in=32'hFFFF_FFFC gives sequential target 0. Negative offsets wrap likewise.
- link_we=1 only when E=1, state=RUN, stall=0, no halt condition, and the opcode is JAL or R-type funct JALR. link_addr=PC_in+4 always.
- During E=0, instr/rs_val/rt_val are don't-care and have no effect.
- In HALT: Next_PC frozen, link_we=0, halted=1.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: a JR/JALR with rs_val[1:0]!=0 sets Next_PC<=TRAP_VECTOR and trap<=1 (sticky until Reset). link_we is suppressed for that instruction. Priority is below halt, above stall.
- Undefined: the target's low two bits are forced to 2'b00, and trap is tied to 0.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE), funct constants (FN_JR, FN_JALR), state enum (ST_RUN, ST_HALT), word width 32.
- One natural combinational sub-module: pc_target_calc. It takes PC_in, instr, rs_val, rt_val and returns the selected target and is_link. pc_sequencer holds the state, priority logic and the Next_PC register.

Test Plan:
- Reset, then sequential flow: Reset for 2 cycles, E toggling, non-branch instrs. Next_PC=0 after reset, then 4, 8, 12, each updating only after an E=1 edge.
- BEQ taken backward: PC_in=0x40, instr=0x1000_FFFE, rs_val=rt_val=5. Next_PC=0x3C. Same case with rt_val=6 gives Next_PC=0x44.
- JAL: PC_in=0x1000_0010, instr=0x0C00_0040. Next_PC=0x1000_0100, link_we=1, link_addr=0x1000_0014.
- Stall beats branch: JR with rs_val=0x200 and stall=1 at PC_in=0x20. Next_PC=0x20, link_we=0. Next execute cycle with stall=0 gives Next_PC=0x200.
- Halt then reset: instr=0xFFFF_FFFF at PC_in=0x30. halted=1, Next_PC frozen at its prior value for 10 cycles. Reset asserted mid-execute returns Next_PC=RESET_VECTOR, halted=0.
- Wrap and misalign: PC_in=0xFFFF_FFFC non-branch gives Next_PC=0. JR with rs_val=0x103 gives Next_PC=0x80 and trap=1 with MISALIGN_TRAP_EN defined, or 0x100 and trap=0 without it.
